interrupt_ack_sequencer: RTL and testbench

Sequencing controller for the 8259A-style in-service path: resolves pending requests against in-service levels under rotating priority, raises INT, runs the two-pulse INTA handshake and owns the in-service register. It applies OCW2 end-of-interrupt and rotation commands, sits between the IRR/IMR block and the data-bus buffer, and supplies the vector byte.

---
 rtl/interrupt_ack_sequencer_pkg.sv | 48 ++++
 rtl/interrupt_ack_sequencer_if.sv | 38 +++
 rtl/interrupt_ack_sequencer_priority_resolver.sv | 28 ++
 rtl/interrupt_ack_sequencer.sv | 165 ++++++++++++++++
 tb/tb_interrupt_ack_sequencer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared types, OCW2 command encodings and level/one-hot helpers for the
// interrupt acknowledge sequencer.
package pic_pkg;

    localparam int NUM_IRQ = 8;

    typedef logic [2:0]         level_t;
    typedef logic [NUM_IRQ-1:0] irq_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK1,
        ST_WAIT2,
        ST_ACK2
    } state_e;

    // OCW2 {R, SL, EOI}
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NSEOI        = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SEOI         = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NSEOI    = 3'b101;
    localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
    localparam logic [2:0] OCW2_ROT_SEOI     = 3'b111;

    function automatic irq_vec_t level_to_onehot(input level_t level);
        irq_vec_t v;
        v        = '0;
        v[level] = 1'b1;
        return v;
    endfunction

    function automatic level_t onehot_to_level(input irq_vec_t v);
        level_t level;
        level = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (v[i]) level = level_t'(i);
        end
        return level;
    endfunction

    // 0 = highest priority; the level just after lowest_level ranks first.
    function automatic level_t prio_rank(input level_t level, input level_t lowest);
        return level - lowest - 3'd1;
    endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_if.sv
// Request, command and vector signals between the sequencer and its
// neighbours (IRR/IMR block, data-bus buffer, CPU acknowledge).
interface interrupt_ack_sequencer_if;
    import pic_pkg::*;

    logic           inta_n;
    irq_vec_t       irr;
    irq_vec_t       imr;
    logic           special_mask_mode;
    logic           auto_eoi;
    logic [4:0]     vector_base;
    logic           ocw2_write;
    logic [2:0]     ocw2_cmd;
    level_t         ocw2_level;

    logic           int_out;
    irq_vec_t       isr;
    irq_vec_t       clear_irr;
    logic [7:0]     data_out;
    logic           data_out_en;
    irq_vec_t       last_serviced;
    level_t         lowest_level;

    modport master (
        output inta_n, irr, imr, special_mask_mode, auto_eoi, vector_base,
               ocw2_write, ocw2_cmd, ocw2_level,
        input  int_out, isr, clear_irr, data_out, data_out_en,
               last_serviced, lowest_level
    );

    modport slave (
        input  inta_n, irr, imr, special_mask_mode, auto_eoi, vector_base,
               ocw2_write, ocw2_cmd, ocw2_level,
        output int_out, isr, clear_irr, data_out, data_out_en,
               last_serviced, lowest_level
    );

endinterface

// File: rtl/interrupt_ack_sequencer_priority_resolver.sv
// Rotating-priority resolver: returns the one-hot highest-priority request,
// where priority starts just above lowest_i and rises cyclically.
module priority_resolver
    import pic_pkg::*;
(
    input  irq_vec_t req_i,
    input  level_t   lowest_i,
    output irq_vec_t grant_o,
    output logic     valid_o
);

    level_t idx;

    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves a value held and no latch is inferred.
    always_comb begin
        grant_o = '0;
        idx     = '0;
        // Walk from lowest priority to highest so the last hit wins.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            idx = lowest_i + level_t'(i + 1);
            if (req_i[idx]) grant_o = level_to_onehot(idx);
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259A-style in-service sequencer: raises INT, runs the two-pulse INTA
// handshake, owns the ISR and applies OCW2 EOI/rotation commands.
module interrupt_ack_sequencer
    import pic_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    interrupt_ack_sequencer_if.slave   bus
);

    state_e     state_q, state_d;
    logic       inta_prev_q;
    irq_vec_t   sel_q, sel_d;
    level_t     level_q, level_d;
    logic       rot_aeoi_q, rot_aeoi_d;
    logic       int_q, int_d;
    irq_vec_t   isr_q, isr_d;
    irq_vec_t   clear_irr_q, clear_irr_d;
    logic [7:0] data_q, data_d;
    logic       data_en_q, data_en_d;
    irq_vec_t   last_q, last_d;
    level_t     lowest_q, lowest_d;

    irq_vec_t   cand, cand_hi, isr_hi, blk, ack_set, eoi_clr;
    logic       cand_valid, isr_valid, blocked, fall, rise;
    level_t     cand_rank;

    assign fall = !bus.inta_n &&  inta_prev_q;
    assign rise =  bus.inta_n && !inta_prev_q;

    assign cand = bus.irr & ~bus.imr;
    // In special mask mode a masked in-service level no longer blocks.
    assign blk  = bus.special_mask_mode ? (isr_q & ~bus.imr) : isr_q;

    priority_resolver u_cand_res (
        .req_i    (cand),
        .lowest_i (lowest_q),
        .grant_o  (cand_hi),
        .valid_o  (cand_valid)
    );

    priority_resolver u_isr_res (
        .req_i    (isr_q),
        .lowest_i (lowest_q),
        .grant_o  (isr_hi),
        .valid_o  (isr_valid)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        level_d     = level_q;
        rot_aeoi_d  = rot_aeoi_q;
        clear_irr_d = '0;
        last_d      = last_q;
        data_d      = data_q;
        data_en_d   = data_en_q;
        lowest_d    = lowest_q;
        ack_set     = '0;
        eoi_clr     = '0;

        case (state_q)
            ST_IDLE: if (fall) begin
                state_d = ST_ACK1;
                if (cand_valid) begin
                    sel_d       = cand_hi;
                    level_d     = onehot_to_level(cand_hi);
                    ack_set     = cand_hi;
                    clear_irr_d = cand_hi;
                    last_d      = cand_hi;
                end else begin
                    sel_d   = '0;
                    level_d = 3'd7;
                end
            end
            ST_ACK1: if (rise) state_d = ST_WAIT2;
            ST_WAIT2: if (fall) begin
                state_d   = ST_ACK2;
                data_d    = {bus.vector_base, level_q};
                data_en_d = 1'b1;
            end
            ST_ACK2: if (rise) begin
                state_d   = ST_IDLE;
                data_en_d = 1'b0;
                if (bus.auto_eoi) begin
                    eoi_clr = sel_q;
                    if (rot_aeoi_q && (sel_q != '0)) lowest_d = level_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.ocw2_write) begin
            case (bus.ocw2_cmd)
                OCW2_NSEOI: if (!bus.special_mask_mode && isr_valid) eoi_clr |= isr_hi;
                OCW2_SEOI:  eoi_clr |= level_to_onehot(bus.ocw2_level);
                OCW2_ROT_NSEOI: if (isr_valid) begin
                    eoi_clr |= isr_hi;
                    lowest_d = onehot_to_level(isr_hi);
                end
                OCW2_ROT_SEOI: if (isr_q[bus.ocw2_level]) begin
                    eoi_clr |= level_to_onehot(bus.ocw2_level);
                    lowest_d = bus.ocw2_level;
                end
                OCW2_SET_PRI:      lowest_d   = bus.ocw2_level;
                OCW2_ROT_AEOI_SET: rot_aeoi_d = 1'b1;
                OCW2_ROT_AEOI_CLR: rot_aeoi_d = 1'b0;
                default: ;
            endcase
        end

        // Acknowledge set takes precedence over a same-cycle clear.
        isr_d = (isr_q & ~eoi_clr) | ack_set;
    end

    always_comb begin
        cand_rank = prio_rank(onehot_to_level(cand_hi), lowest_q);
        blocked   = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (blk[i] && (prio_rank(level_t'(i), lowest_q) <= cand_rank)) blocked = 1'b1;
        end
        int_d = (state_d == ST_IDLE) && cand_valid && !blocked;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            inta_prev_q <= 1'b1;
            sel_q       <= '0;
            level_q     <= '0;
            rot_aeoi_q  <= 1'b0;
            int_q       <= 1'b0;
            isr_q       <= '0;
            clear_irr_q <= '0;
            data_q      <= '0;
            data_en_q   <= 1'b0;
            last_q      <= '0;
            lowest_q    <= 3'd7;
        end else begin
            state_q     <= state_d;
            inta_prev_q <= bus.inta_n;
            sel_q       <= sel_d;
            level_q     <= level_d;
            rot_aeoi_q  <= rot_aeoi_d;
            int_q       <= int_d;
            isr_q       <= isr_d;
            clear_irr_q <= clear_irr_d;
            data_q      <= data_d;
            data_en_q   <= data_en_d;
            last_q      <= last_d;
            lowest_q    <= lowest_d;
        end
    end

    assign bus.int_out       = int_q;
    assign bus.isr           = isr_q;
    assign bus.clear_irr     = clear_irr_q;
    assign bus.data_out      = data_q;
    assign bus.data_out_en   = data_en_q;
    assign bus.last_serviced = last_q;
    assign bus.lowest_level  = lowest_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer: inputs change and outputs are
// sampled on the falling clock edge.
module tb_interrupt_ack_sequencer;
    import pic_pkg::*;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    interrupt_ack_sequencer_if bus ();

    interrupt_ack_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic ocw2(input logic [2:0] cmd, input logic [2:0] level);
        bus.ocw2_write = 1'b1;
        bus.ocw2_cmd   = cmd;
        bus.ocw2_level = level;
        tick(1);
        bus.ocw2_write = 1'b0;
    endtask

    // Full INTA pair; the request is dropped after the first pulse as the IRR block would.
    task automatic full_ack();
        bus.inta_n = 1'b0; tick(1);
        bus.irr    = '0;
        bus.inta_n = 1'b1; tick(1);
        bus.inta_n = 1'b0; tick(1);
        bus.inta_n = 1'b1; tick(1);
    endtask

    task automatic test_reset();
        bus.inta_n = 1'b1; bus.irr = '0; bus.imr = '0;
        bus.special_mask_mode = 1'b0; bus.auto_eoi = 1'b0; bus.vector_base = 5'h01;
        bus.ocw2_write = 1'b0; bus.ocw2_cmd = '0; bus.ocw2_level = '0;
        reset = 1'b1;
        tick(2);
        checks++; if (bus.int_out !== 1'b0) begin errors++; $display("FAIL reset_int: got %b want 0", bus.int_out); end
        checks++; if (bus.isr !== 8'h00) begin errors++; $display("FAIL reset_isr: got %h want 00", bus.isr); end
        checks++; if (bus.clear_irr !== 8'h00) begin errors++; $display("FAIL reset_clear_irr: got %h want 00", bus.clear_irr); end
        checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.data_out); end
        checks++; if (bus.data_out_en !== 1'b0) begin errors++; $display("FAIL reset_data_en: got %b want 0", bus.data_out_en); end
        checks++; if (bus.last_serviced !== 8'h00) begin errors++; $display("FAIL reset_last: got %h want 00", bus.last_serviced); end
        checks++; if (bus.lowest_level !== 3'd7) begin errors++; $display("FAIL reset_lowest: got %0d want 7", bus.lowest_level); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_basic_ack();
        bus.irr = 8'h04;
        tick(2);
        checks++; if (bus.int_out !== 1'b1) begin errors++; $display("FAIL basic_int: got %b want 1", bus.int_out); end
        bus.inta_n = 1'b0; tick(1);
        checks++; if (bus.isr !== 8'h04) begin errors++; $display("FAIL basic_isr: got %h want 04", bus.isr); end
        checks++; if (bus.clear_irr !== 8'h04) begin errors++; $display("FAIL basic_clear_irr: got %h want 04", bus.clear_irr); end
        checks++; if (bus.last_serviced !== 8'h04) begin errors++; $display("FAIL basic_last: got %h want 04", bus.last_serviced); end
        checks++; if (bus.int_out !== 1'b0) begin errors++; $display("FAIL basic_int_ack1: got %b want 0", bus.int_out); end
        bus.irr = '0; tick(1);
        checks++; if (bus.clear_irr !== 8'h00) begin errors++; $display("FAIL basic_clear_pulse: got %h want 00", bus.clear_irr); end
        bus.inta_n = 1'b1; tick(2);
        bus.inta_n = 1'b0; tick(1);
        checks++; if (bus.data_out !== 8'h0A) begin errors++; $display("FAIL basic_vector: got %h want 0A", bus.data_out); end
        checks++; if (bus.data_out_en !== 1'b1) begin errors++; $display("FAIL basic_en_on: got %b want 1", bus.data_out_en); end
        bus.inta_n = 1'b1; tick(1);
        checks++; if (bus.data_out_en !== 1'b0) begin errors++; $display("FAIL basic_en_off: got %b want 0", bus.data_out_en); end
        checks++; if (bus.data_out !== 8'h0A) begin errors++; $display("FAIL basic_vector_hold: got %h want 0A", bus.data_out); end
        checks++; if (bus.isr !== 8'h04) begin errors++; $display("FAIL basic_isr_kept: got %h want 04", bus.isr); end
        checks++; if (bus.int_out !== 1'b0) begin errors++; $display("FAIL basic_int_after: got %b want 0", bus.int_out); end
    endtask

    task automatic test_nested();
        bus.irr = 8'h01; tick(2);
        checks++; if (bus.int_out !== 1'b1) begin errors++; $display("FAIL nested_ir0_int: got %b want 1", bus.int_out); end
        bus.irr = 8'h10; tick(2);
        checks++; if (bus.int_out !== 1'b0) begin errors++; $display("FAIL nested_ir4_blocked: got %b want 0", bus.int_out); end
        ocw2(OCW2_NSEOI, 3'd0);
        checks++; if (bus.isr !== 8'h00) begin errors++; $display("FAIL nested_nseoi_isr: got %h want 00", bus.isr); end
        tick(1);
        checks++; if (bus.int_out !== 1'b1) begin errors++; $display("FAIL nested_ir4_int: got %b want 1", bus.int_out); end
        bus.irr = '0; tick(2);
    endtask

    task automatic test_auto_eoi_rotate();
        bus.auto_eoi = 1'b1;
        ocw2(OCW2_ROT_AEOI_SET, 3'd0);
        bus.irr = 8'h08; tick(2);
        bus.inta_n = 1'b0; tick(1);
        checks++; if (bus.isr !== 8'h08) begin errors++; $display("FAIL aeoi_isr_set: got %h want 08", bus.isr); end
        bus.irr = '0;
        bus.inta_n = 1'b1; tick(1);
        bus.inta_n = 1'b0; tick(1);
        checks++; if (bus.data_out !== 8'h0B) begin errors++; $display("FAIL aeoi_vector: got %h want 0B", bus.data_out); end
        bus.inta_n = 1'b1; tick(1);
        checks++; if (bus.isr !== 8'h00) begin errors++; $display("FAIL aeoi_isr_clear: got %h want 00", bus.isr); end
        checks++; if (bus.lowest_level !== 3'd3) begin errors++; $display("FAIL aeoi_lowest: got %0d want 3", bus.lowest_level); end
        bus.irr = 8'h11; tick(2);
        bus.inta_n = 1'b0; tick(1);
        checks++; if (bus.last_serviced !== 8'h10) begin errors++; $display("FAIL aeoi_ir4_first: got %h want 10", bus.last_serviced); end
        bus.irr = '0;
        bus.inta_n = 1'b1; tick(1);
        bus.inta_n = 1'b0; tick(1);
        bus.inta_n = 1'b1; tick(1);
        checks++; if (bus.lowest_level !== 3'd4) begin errors++; $display("FAIL aeoi_lowest2: got %0d want 4", bus.lowest_level); end
        ocw2(OCW2_ROT_AEOI_CLR, 3'd0);
        bus.auto_eoi = 1'b0;
        ocw2(OCW2_SET_PRI, 3'd7);
        checks++; if (bus.lowest_level !== 3'd7) begin errors++; $display("FAIL set_pri: got %0d want 7", bus.lowest_level); end
    endtask

    task automatic test_spurious();
        bus.irr = 8'h04; tick(2);
        checks++; if (bus.int_out !== 1'b1) begin errors++; $display("FAIL spur_int: got %b want 1", bus.int_out); end
        bus.irr = '0; tick(1);
        bus.inta_n = 1'b0; tick(1);
        checks++; if (bus.isr !== 8'h00) begin errors++; $display("FAIL spur_isr: got %h want 00", bus.isr); end
        checks++; if (bus.clear_irr !== 8'h00) begin errors++; $display("FAIL spur_clear_irr: got %h want 00", bus.clear_irr); end
        checks++; if (bus.last_serviced !== 8'h10) begin errors++; $display("FAIL spur_last: got %h want 10", bus.last_serviced); end
        bus.inta_n = 1'b1; tick(1);
        bus.inta_n = 1'b0; tick(1);
        checks++; if (bus.data_out !== 8'h0F) begin errors++; $display("FAIL spur_vector: got %h want 0F", bus.data_out); end
        bus.inta_n = 1'b1; tick(1);
    endtask

    task automatic test_ocw2();
        bus.irr = 8'h20; tick(2);
        full_ack();
        bus.irr = 8'h01; tick(2);
        checks++; if (bus.int_out !== 1'b1) begin errors++; $display("FAIL ocw2_nest_int: got %b want 1", bus.int_out); end
        full_ack();
        checks++; if (bus.isr !== 8'h21) begin errors++; $display("FAIL ocw2_isr_21: got %h want 21", bus.isr); end
        ocw2(OCW2_ROT_SEOI, 3'd5);
        checks++; if (bus.isr !== 8'h01) begin errors++; $display("FAIL rot_seoi_isr: got %h want 01", bus.isr); end
        checks++; if (bus.lowest_level !== 3'd5) begin errors++; $display("FAIL rot_seoi_lowest: got %0d want 5", bus.lowest_level); end
        bus.irr = 8'h02; bus.imr = 8'h01; bus.special_mask_mode = 1'b1; tick(2);
        checks++; if (bus.int_out !== 1'b1) begin errors++; $display("FAIL smm_unblocked: got %b want 1", bus.int_out); end
        bus.special_mask_mode = 1'b0; tick(2);
        checks++; if (bus.int_out !== 1'b0) begin errors++; $display("FAIL smm_off_blocked: got %b want 0", bus.int_out); end
        bus.irr = '0; bus.imr = '0; bus.special_mask_mode = 1'b1;
        ocw2(OCW2_NSEOI, 3'd0);
        checks++; if (bus.isr !== 8'h01) begin errors++; $display("FAIL smm_nseoi_ignored: got %h want 01", bus.isr); end
        bus.special_mask_mode = 1'b0;
        ocw2(OCW2_SEOI, 3'd0);
        checks++; if (bus.isr !== 8'h00) begin errors++; $display("FAIL seoi_isr: got %h want 00", bus.isr); end
        ocw2(OCW2_SET_PRI, 3'd7);
        tick(1);
    endtask

    task automatic test_reset_mid();
        bus.irr = 8'h04; tick(2);
        bus.inta_n = 1'b0; tick(1);
        bus.irr = '0;
        bus.inta_n = 1'b1; tick(1);
        ocw2(OCW2_SET_PRI, 3'd2);
        reset = 1'b1; tick(1);
        checks++; if (bus.isr !== 8'h00) begin errors++; $display("FAIL rst_mid_isr: got %h want 00", bus.isr); end
        checks++; if (bus.data_out_en !== 1'b0) begin errors++; $display("FAIL rst_mid_en: got %b want 0", bus.data_out_en); end
        checks++; if (bus.lowest_level !== 3'd7) begin errors++; $display("FAIL rst_mid_lowest: got %0d want 7", bus.lowest_level); end
        reset = 1'b0; tick(1);
        bus.irr = 8'h04; tick(2);
        bus.inta_n = 1'b0; tick(1);
        checks++; if (bus.clear_irr !== 8'h04) begin errors++; $display("FAIL rst_after_clear: got %h want 04", bus.clear_irr); end
        bus.irr = '0;
        bus.inta_n = 1'b1; tick(1);
        bus.inta_n = 1'b0; tick(1);
        checks++; if (bus.data_out !== 8'h0A || bus.data_out_en !== 1'b1) begin
            errors++; $display("FAIL rst_after_vector: got %h/%b want 0A/1", bus.data_out, bus.data_out_en);
        end
        bus.inta_n = 1'b1; tick(1);
        checks++; if (bus.data_out_en !== 1'b0) begin errors++; $display("FAIL rst_after_en_off: got %b want 0", bus.data_out_en); end
    endtask

    initial begin
        test_reset();
        test_basic_ack();
        test_nested();
        test_auto_eoi_rotate();
        test_spurious();
        test_ocw2();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
